lsu_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the single AHB-Lite master request/response port (the ahbm_lsu_* interface of the AHB subsystem) between the core LSU (port m0) and a second bus requester (port m1, e.g. debug loader or DMA).
- Strictly one outstanding transaction at a time.
- Round-robin or fixed-priority grant.
- Response routed back to the owning requester.
- Sits in the SoC top between core_top/second master and ahb_lite_top.

---
 rtl/lsu_bus_arbiter.sv | 96 +++++++++
 tb/tb_lsu_bus_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter: shares one valid/ready bus port between two requesters with a
// single outstanding transaction, using round-robin or fixed-priority grant.
module lsu_bus_arbiter #(
   parameter int PRIO_MODE = 0,
   parameter int WR_RSP    = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        m0_req_vld,
   output logic        m0_req_rdy,
   input  logic        m0_req_wen,
   input  logic [2:0]  m0_req_rwtyp,
   input  logic [31:0] m0_req_addr,
   input  logic [31:0] m0_req_wdata,
   output logic        m0_rsp_vld,
   input  logic        m0_rsp_rdy,
   output logic [31:0] m0_rsp_rdata,
   input  logic        m1_req_vld,
   output logic        m1_req_rdy,
   input  logic        m1_req_wen,
   input  logic [2:0]  m1_req_rwtyp,
   input  logic [31:0] m1_req_addr,
   input  logic [31:0] m1_req_wdata,
   output logic        m1_rsp_vld,
   input  logic        m1_rsp_rdy,
   output logic [31:0] m1_rsp_rdata,
   output logic        s_req_vld,
   input  logic        s_req_rdy,
   output logic        s_req_wen,
   output logic [2:0]  s_req_rwtyp,
   output logic [31:0] s_req_addr,
   output logic [31:0] s_req_wdata,
   input  logic        s_rsp_vld,
   output logic        s_rsp_rdy,
   input  logic [31:0] s_rsp_rdata,
   output logic        arb_busy,
   output logic        arb_owner
);
   typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
   state_e state_q, state_d;
   logic owner_q, owner_d, last_q, last_d;
   logic gnt, in_req, in_rsp, own_rsp_rdy;

   // On contention round-robin picks whoever did not win last time
   assign gnt = (m0_req_vld && m1_req_vld) ? (PRIO_MODE != 0 ? 1'b0 : ~last_q) : m1_req_vld;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         IDLE: if (m0_req_vld || m1_req_vld) begin
            state_d = REQ;
            owner_d = gnt;
            last_d  = gnt;
         end
         REQ: if (s_req_rdy) state_d = (s_req_wen && WR_RSP == 0) ? IDLE : RSP;
         RSP: if (s_rsp_vld && own_rsp_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_req      = state_q == REQ;
   assign in_rsp      = state_q == RSP;
   assign own_rsp_rdy = owner_q ? m1_rsp_rdy : m0_rsp_rdy;

   assign s_req_vld   = in_req;
   assign s_req_wen   = in_req && (owner_q ? m1_req_wen : m0_req_wen);
   assign s_req_rwtyp = in_req ? (owner_q ? m1_req_rwtyp : m0_req_rwtyp) : 3'd0;
   assign s_req_addr  = in_req ? (owner_q ? m1_req_addr : m0_req_addr) : 32'd0;
   assign s_req_wdata = in_req ? (owner_q ? m1_req_wdata : m0_req_wdata) : 32'd0;
   assign m0_req_rdy  = in_req && !owner_q && s_req_rdy;
   assign m1_req_rdy  = in_req && owner_q && s_req_rdy;

   // Stray downstream responses outside RSP never reach a requester
   assign s_rsp_rdy    = in_rsp && own_rsp_rdy;
   assign m0_rsp_vld   = in_rsp && !owner_q && s_rsp_vld;
   assign m1_rsp_vld   = in_rsp && owner_q && s_rsp_vld;
   assign m0_rsp_rdata = (in_rsp && !owner_q) ? s_rsp_rdata : 32'd0;
   assign m1_rsp_rdata = (in_rsp && owner_q) ? s_rsp_rdata : 32'd0;

   assign arb_busy  = state_q != IDLE;
   assign arb_owner = owner_q;
endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// tb_lsu_bus_arbiter: four arbiter configurations (grant mode x write-response mode) under
// shared random traffic, checked against a transaction-level model through scoreboard queues.
module tb_lsu_bus_arbiter;
   localparam int NK = 4;
   localparam int IDLE = 0, REQ = 1, RSP = 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic        m_req_vld [NK][2], m_req_rdy [NK][2], m_req_wen [NK][2];
   logic [2:0]  m_req_rwtyp [NK][2];
   logic [31:0] m_req_addr [NK][2], m_req_wdata [NK][2];
   logic        m_rsp_vld [NK][2], m_rsp_rdy [NK][2];
   logic [31:0] m_rsp_rdata [NK][2];
   logic        s_req_vld [NK], s_req_rdy [NK], s_req_wen [NK];
   logic [2:0]  s_req_rwtyp [NK];
   logic [31:0] s_req_addr [NK], s_req_wdata [NK];
   logic        s_rsp_vld [NK], s_rsp_rdy [NK];
   logic [31:0] s_rsp_rdata [NK];
   logic        arb_busy [NK], arb_owner [NK];

   // Instance k: PRIO_MODE = k%2, WR_RSP = (k<2)
   for (genvar k = 0; k < NK; k++) begin : g
      lsu_bus_arbiter #(.PRIO_MODE(k % 2), .WR_RSP(k < 2 ? 1 : 0)) dut (
         .clk(clk), .rstn(rstn),
         .m0_req_vld(m_req_vld[k][0]), .m0_req_rdy(m_req_rdy[k][0]), .m0_req_wen(m_req_wen[k][0]),
         .m0_req_rwtyp(m_req_rwtyp[k][0]), .m0_req_addr(m_req_addr[k][0]), .m0_req_wdata(m_req_wdata[k][0]),
         .m0_rsp_vld(m_rsp_vld[k][0]), .m0_rsp_rdy(m_rsp_rdy[k][0]), .m0_rsp_rdata(m_rsp_rdata[k][0]),
         .m1_req_vld(m_req_vld[k][1]), .m1_req_rdy(m_req_rdy[k][1]), .m1_req_wen(m_req_wen[k][1]),
         .m1_req_rwtyp(m_req_rwtyp[k][1]), .m1_req_addr(m_req_addr[k][1]), .m1_req_wdata(m_req_wdata[k][1]),
         .m1_rsp_vld(m_rsp_vld[k][1]), .m1_rsp_rdy(m_rsp_rdy[k][1]), .m1_rsp_rdata(m_rsp_rdata[k][1]),
         .s_req_vld(s_req_vld[k]), .s_req_rdy(s_req_rdy[k]), .s_req_wen(s_req_wen[k]),
         .s_req_rwtyp(s_req_rwtyp[k]), .s_req_addr(s_req_addr[k]), .s_req_wdata(s_req_wdata[k]),
         .s_rsp_vld(s_rsp_vld[k]), .s_rsp_rdy(s_rsp_rdy[k]), .s_rsp_rdata(s_rsp_rdata[k]),
         .arb_busy(arb_busy[k]), .arb_owner(arb_owner[k])
      );
   end

   typedef struct packed {logic own; logic wen; logic [2:0] typ; logic [31:0] addr; logic [31:0] wdata;} req_t;
   typedef struct packed {logic own; logic [31:0] data;} rsp_t;
   req_t req_q [NK][$];
   rsp_t rsp_q [NK][$];

   // Transaction-level model: bus phase, owner and last winner per instance
   int          ph [NK];
   logic        own [NK], last [NK], dn_hold [NK];
   logic [31:0] rsp_data [NK];
   int          load [2];
   int          sreq_pct, rrdy_pct, spur_pct;
   logic [31:0] rd_fix;
   int          hit = -1;

   int errs = 0, chks = 0;
   logic hit_chk = 1'b0;
   logic o, rq, rs;
   req_t e;
   rsp_t r;

   task automatic mreset();
      for (int k = 0; k < NK; k++) begin
         ph[k] = IDLE; own[k] = 1'b0; last[k] = 1'b1; dn_hold[k] = 1'b0;
         s_rsp_vld[k] = 1'b0;
         req_q[k].delete(); rsp_q[k].delete();
      end
   endtask

   task automatic step();
      logic w;
      @(posedge clk);
      #1;
      for (int k = 0; k < NK; k++) begin
         if (rstn) begin
            if (ph[k] == IDLE && (m_req_vld[k][0] || m_req_vld[k][1])) begin
               w = (m_req_vld[k][0] && m_req_vld[k][1]) ? ((k % 2 == 1) ? 1'b0 : !last[k]) : m_req_vld[k][1];
               own[k] = w; last[k] = w; ph[k] = REQ;
               req_q[k].push_back('{w, m_req_wen[k][w], m_req_rwtyp[k][w], m_req_addr[k][w], m_req_wdata[k][w]});
            end else if (ph[k] == REQ && s_req_rdy[k]) begin
               m_req_vld[k][own[k]] = 1'b0;
               if (m_req_wen[k][own[k]] && k >= 2) ph[k] = IDLE;
               else begin
                  rsp_data[k] = (rd_fix != 0) ? rd_fix : $urandom;
                  rsp_q[k].push_back('{own[k], rsp_data[k]});
                  ph[k] = RSP;
               end
            end else if (ph[k] == RSP && s_rsp_vld[k] && m_rsp_rdy[k][own[k]]) ph[k] = IDLE;
         end
         for (int p = 0; p < 2; p++) begin
            if (!m_req_vld[k][p] && int'($urandom_range(99)) < load[p]) begin
               m_req_vld[k][p]   = 1'b1;
               m_req_wen[k][p]   = 1'($urandom_range(1));
               m_req_rwtyp[k][p] = 3'($urandom);
               m_req_addr[k][p]  = $urandom;
               m_req_wdata[k][p] = $urandom;
            end
            m_rsp_rdy[k][p] = int'($urandom_range(99)) < rrdy_pct;
         end
         s_req_rdy[k] = int'($urandom_range(99)) < sreq_pct;
         if (ph[k] == RSP) begin
            if (!dn_hold[k]) dn_hold[k] = $urandom_range(1) == 1;
            s_rsp_vld[k]   = dn_hold[k];
            s_rsp_rdata[k] = dn_hold[k] ? rsp_data[k] : $urandom;
         end else begin
            dn_hold[k]     = 1'b0;
            s_rsp_vld[k]   = int'($urandom_range(99)) < spur_pct;
            s_rsp_rdata[k] = $urandom;
         end
      end
   endtask

   task automatic preset(input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
      for (int k = 0; k < NK; k++) begin
         m_req_vld[k][0] = 1'b1; m_req_wen[k][0] = wen; m_req_rwtyp[k][0] = 3'b010;
         m_req_addr[k][0] = addr; m_req_wdata[k][0] = wdata;
      end
   endtask

   task automatic chk(input string name, input int k, input logic [95:0] act, input logic [95:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < NK; k++) begin
         o  = own[k];
         rq = ph[k] == REQ;
         rs = ph[k] == RSP;
         chk("busy", k, 96'(arb_busy[k]), 96'(ph[k] != IDLE));
         chk("owner", k, 96'(arb_owner[k]), 96'(o));
         chk("s_req_vld", k, 96'(s_req_vld[k]), 96'(rq));
         chk("s_req_fields", k, 96'({s_req_wen[k], s_req_rwtyp[k], s_req_addr[k], s_req_wdata[k]}),
             rq ? 96'({m_req_wen[k][o], m_req_rwtyp[k][o], m_req_addr[k][o], m_req_wdata[k][o]}) : 96'd0);
         chk("s_rsp_rdy", k, 96'(s_rsp_rdy[k]), 96'(rs && m_rsp_rdy[k][o]));
         if (s_req_vld[k] && s_req_rdy[k]) begin
            chk("req_q_empty", k, 96'(req_q[k].size() == 0), 96'd0);
            if (req_q[k].size() != 0) begin
               e = req_q[k].pop_front();
               chk("grant", k, 96'(arb_owner[k]), 96'(e.own));
               chk("req_fields", k, 96'({s_req_wen[k], s_req_rwtyp[k], s_req_addr[k], s_req_wdata[k]}),
                   96'({e.wen, e.typ, e.addr, e.wdata}));
            end
         end
         for (int p = 0; p < 2; p++) begin
            chk("req_rdy", k, 96'(m_req_rdy[k][p]), 96'(rq && o == p[0] && s_req_rdy[k]));
            chk("rsp_vld", k, 96'(m_rsp_vld[k][p]), 96'(rs && o == p[0] && s_rsp_vld[k]));
            if (!(rs && o == p[0])) chk("rsp_rdata_idle", k, 96'(m_rsp_rdata[k][p]), 96'd0);
            if (m_rsp_vld[k][p] && m_rsp_rdy[k][p]) begin
               chk("rsp_q_empty", k, 96'(rsp_q[k].size() == 0), 96'd0);
               if (rsp_q[k].size() != 0) begin
                  r = rsp_q[k].pop_front();
                  chk("rsp_port", k, 96'(p), 96'(r.own));
                  chk("rsp_rdata", k, 96'(m_rsp_rdata[k][p]), 96'(r.data));
               end
            end
         end
      end
      if (!rstn && hit >= 0 && !hit_chk) begin
         hit_chk = 1'b1;
         chk("rsp_before_reset", 0, 96'(hit), 96'd1);
      end
   end

   initial begin
      for (int k = 0; k < NK; k++) begin
         for (int p = 0; p < 2; p++) begin
            m_req_vld[k][p] = 1'b0; m_req_wen[k][p] = 1'b0; m_req_rwtyp[k][p] = 3'd0;
            m_req_addr[k][p] = 32'd0; m_req_wdata[k][p] = 32'd0; m_rsp_rdy[k][p] = 1'b0;
         end
         s_req_rdy[k] = 1'b0; s_rsp_rdata[k] = 32'd0; rsp_data[k] = 32'd0;
      end
      mreset();
      load = '{0, 0}; sreq_pct = 100; rrdy_pct = 100; spur_pct = 0; rd_fix = 32'd0;
      repeat (3) step();
      rstn = 1'b1;
      rd_fix = 32'hA5A5_5A5A;
      preset(1'b0, 32'h0000_1000, 32'd0);
      repeat (10) step();
      rd_fix = 32'd0;
      preset(1'b1, 32'h1000_0004, 32'h0000_0055);
      repeat (10) step();
      load = '{100, 100};
      repeat (60) step();
      load[0] = 0;
      repeat (20) step();
      load = '{50, 50}; sreq_pct = 30; rrdy_pct = 30; spur_pct = 10;
      repeat (400) step();
      load = '{30, 30}; sreq_pct = 70; rrdy_pct = 70;
      repeat (1000) step();
      hit = 0;
      for (int n = 0; n < 200 && hit == 0; n++) begin
         step();
         if (ph[0] == RSP) hit = 1;
      end
      rstn = 1'b0;
      mreset();
      repeat (2) step();
      rstn = 1'b1;
      load = '{100, 100}; sreq_pct = 100; rrdy_pct = 100; spur_pct = 0;
      repeat (40) step();
      load = '{0, 0};
      repeat (30) step();
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
